// File: rtl/regport_seq.sv
// regport_seq: serialises two operand reads and an optional write onto a single-port register file.
// Define REGPORT_WRITE_FIRST_EN to perform the write before the reads (reads then see the new value).
module regport_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic            rd_we,
  input  logic [XLEN-1:0] rd_wdata,
  output logic [31:0]     rf_register,
  output logic            rf_writeEnable,
  output logic [XLEN-1:0] rf_writeData,
  input  logic [XLEN-1:0] rf_readData,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  typedef enum logic [2:0] {
    StIdle,
    StRd1,
    StRd2,
    StWr,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Latched request fields
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic            we_q;
  logic [XLEN-1:0] wdata_q;

  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic req_hs;
  logic rsp_hs;
  logic do_write;

  assign req_ready = (state_q == StIdle);
  assign req_hs    = req_valid && req_ready;
  assign rsp_hs    = rsp_valid_q && rsp_ready;
  // Writes to x0 are dropped entirely: no WR cycle is scheduled.
  assign do_write  = we_q && (rd_q != 5'd0);

  always_comb begin
    state_d        = state_q;
    rf_register    = 32'd0;
    rf_writeEnable = 1'b0;
    rf_writeData   = '0;
    rs1_data_d     = rs1_data_q;
    rs2_data_d     = rs2_data_q;

    unique case (state_q)
      StIdle: begin
        if (req_hs) begin
`ifdef REGPORT_WRITE_FIRST_EN
          state_d = (rd_we && (rd != 5'd0)) ? StWr : StRd1;
`else
          state_d = StRd1;
`endif
        end
      end
      StRd1: begin
        rf_register = {27'd0, rs1_q};
        rs1_data_d  = rf_readData;
        state_d     = StRd2;
      end
      StRd2: begin
        rf_register = {27'd0, rs2_q};
        rs2_data_d  = rf_readData;
`ifdef REGPORT_WRITE_FIRST_EN
        state_d     = StResp;
`else
        state_d     = do_write ? StWr : StResp;
`endif
      end
      StWr: begin
        rf_register    = {27'd0, rd_q};
        rf_writeEnable = 1'b1;
        rf_writeData   = wdata_q;
`ifdef REGPORT_WRITE_FIRST_EN
        state_d        = StRd1;
`else
        state_d        = StResp;
`endif
      end
      StResp: begin
        if (rsp_hs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // rsp_valid is registered: the first RESP cycle lets the operands settle, and the
  // response is presented from the following cycle until it is accepted.
  assign rsp_valid_d = (state_q == StResp) && !rsp_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      rd_q        <= 5'd0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      rsp_valid_q <= rsp_valid_d;
      if (req_hs) begin
        rs1_q   <= rs1;
        rs2_q   <= rs2;
        rd_q    <= rd;
        we_q    <= rd_we;
        wdata_q <= rd_wdata;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rs1_data  = rs1_data_q;
  assign rs2_data  = rs2_data_q;

endmodule

// File: tb/tb_regport_seq.sv
// Scoreboard bench for regport_seq: stimulus pushes expected operands, a monitor pops on each
// response handshake. A behavioural single-port register file sits on the rf_* port.
module tb_regport_seq;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [4:0]      rs1, rs2, rd;
  logic            rd_we;
  logic [XLEN-1:0] rd_wdata;
  logic [31:0]     rf_register;
  logic            rf_writeEnable;
  logic [XLEN-1:0] rf_writeData;
  logic [XLEN-1:0] rf_readData;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rs1_data, rs2_data;

  always #5 clk = ~clk;

  regport_seq #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd             (rd),
    .rd_we          (rd_we),
    .rd_wdata       (rd_wdata),
    .rf_register    (rf_register),
    .rf_writeEnable (rf_writeEnable),
    .rf_writeData   (rf_writeData),
    .rf_readData    (rf_readData),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data)
  );

  // Register file model with a bench-side preload port
  logic [XLEN-1:0] rf [32];
  logic            pre_we = 1'b0;
  logic [4:0]      pre_idx = 5'd0;
  logic [XLEN-1:0] pre_data = '0;
  int              we_cnt = 0;

  assign rf_readData = rf[rf_register[4:0]];

  always @(posedge clk) begin
    if (pre_we) rf[pre_idx] <= pre_data;
    else if (rf_writeEnable) rf[rf_register[4:0]] <= rf_writeData;
    if (rf_writeEnable) we_cnt <= we_cnt + 1;
  end

  int tests = 0;
  int fails = 0;
  logic [2*XLEN-1:0] exp_q[$];
  logic [2*XLEN-1:0] mon_e;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares on every response handshake
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rs1_data", rs1_data, mon_e[2*XLEN-1:XLEN]);
        check("rs2_data", rs2_data, mon_e[XLEN-1:0]);
      end
    end
  end

  task automatic preload(input logic [4:0] idx, input logic [XLEN-1:0] val);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = val;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Present a request and return #1 after the accepting edge
  task automatic send(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                      input logic we, input logic [XLEN-1:0] wd, input logic keep);
    int n = 0;
    @(negedge clk);
    rs1 = a; rs2 = b; rd = d; rd_we = we; rd_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!rsp_valid && lat < 50);
  endtask

  int lat;
  int w0;

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    rs1 = '0; rs2 = '0; rd = '0; rd_we = 1'b0; rd_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_we", {31'd0, rf_writeEnable}, 32'd0);
    check("rst_rf_register", rf_register, 32'd0);
    check("rst_rs1_data", rs1_data, '0);
    check("rst_rs2_data", rs2_data, '0);
    rst = 1'b0;

    preload(5'd0, 32'h5A);
    preload(5'd3, 32'h33);
    preload(5'd5, 32'h11);
    preload(5'd6, 32'h22);
    preload(5'd7, 32'hA);
    preload(5'd9, 32'h99);

    // Read-only request
    w0 = we_cnt;
    exp_q.push_back({32'h11, 32'h22});
    send(5'd5, 5'd6, 5'd0, 1'b0, '0, 1'b0);
    wait_valid(lat);
    check("ro_latency", XLEN'(lat), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    check("ro_no_write", XLEN'(we_cnt - w0), 32'd0);

    // Read-modify-write of x7
    w0 = we_cnt;
`ifdef REGPORT_WRITE_FIRST_EN
    exp_q.push_back({32'hB, 32'hB});
`else
    exp_q.push_back({32'hA, 32'hA});
`endif
    send(5'd7, 5'd7, 5'd7, 1'b1, 32'hB, 1'b0);
    wait_valid(lat);
    check("rmw_latency", XLEN'(lat), 32'd4);
    repeat (2) @(posedge clk);
    #1;
    check("rmw_one_write", XLEN'(we_cnt - w0), 32'd1);
    check("rmw_x7", rf[7], 32'hB);

    // x0 write suppressed; index 0 reads whatever the file presents
    w0 = we_cnt;
    exp_q.push_back({32'h5A, 32'h33});
    send(5'd0, 5'd3, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    wait_valid(lat);
    check("x0_latency", XLEN'(lat), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    check("x0_no_write", XLEN'(we_cnt - w0), 32'd0);
    check("x0_value", rf[0], 32'h5A);

    // Backpressure with req_valid held high
    rsp_ready = 1'b0;
    exp_q.push_back({32'h11, 32'h22});
    send(5'd5, 5'd6, 5'd0, 1'b0, '0, 1'b1);
    wait_valid(lat);
    check("bp_latency", XLEN'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rs1_data", rs1_data, 32'h11);
      check("bp_rs2_data", rs2_data, 32'h22);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    check("bp_still_busy", {31'd0, req_ready}, 32'd0);
    exp_q.push_back({32'h11, 32'h22});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_after_hs", {31'd0, req_ready}, 32'd1);
    check("bp_valid_dropped", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("bp_next_accepted", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    wait_valid(lat);
    check("bp2_latency", XLEN'(lat), 32'd3);
    repeat (2) @(posedge clk);

    // Reset in the WR cycle: the in-flight write lands, the transaction is abandoned
    send(5'd9, 5'd9, 5'd9, 1'b1, 32'h1234, 1'b0);
    lat = 0;
    while (!rf_writeEnable && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("wr_seen", {31'd0, rf_writeEnable}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rwr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rwr_we", {31'd0, rf_writeEnable}, 32'd0);
    check("rwr_wdata", rf_writeData, '0);
    check("rwr_rf_register", rf_register, 32'd0);
    check("rwr_rs1_data", rs1_data, '0);
    check("rwr_rs2_data", rs2_data, '0);
    check("rwr_req_ready", {31'd0, req_ready}, 32'd1);
    check("rwr_x9", rf[9], 32'h1234);
    repeat (6) @(posedge clk);
    #1;
    check("rwr_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // Recovery after reset
    exp_q.push_back({32'h1234, 32'h11});
    send(5'd9, 5'd5, 5'd0, 1'b0, '0, 1'b0);
    wait_valid(lat);
    check("rec_latency", XLEN'(lat), 32'd3);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drain", XLEN'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regport_seq.md
REGPORT_SEQ -- requirements
Module: regport_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width of the register file and of all data ports.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports req_valid (input, 1) and req_ready (output, 1): the request handshake.
REQ-005 The block SHALL have ports rs1 and rs2 (input, 5 bits each): the source register indices.
REQ-006 The block SHALL have ports rd (input, 5), rd_we (input, 1) and rd_wdata (input, XLEN): the destination index, write request and write data.
REQ-007 The block SHALL have port rf_register, output, 32 bits: the register index driven to the single-port register file, zero-extended from 5 bits.
REQ-008 The block SHALL have ports rf_writeEnable (output, 1) and rf_writeData (output, XLEN): the register-file write strobe and write data.
REQ-009 The block SHALL have port rf_readData, input, XLEN: the combinational read data returned by the register file for rf_register.
REQ-010 The block SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1): the response handshake.
REQ-011 The block SHALL have ports rs1_data and rs2_data, output, XLEN each: the operand values read for the request.

Function
REQ-012 The block SHALL serialise one request (two reads plus an optional write) onto the single-port register file, one access per cycle.
REQ-013 The block SHALL implement the FSM states IDLE, RD1, RD2, WR and RESP.
REQ-014 IDLE transitions:
- req_ready=1 only in IDLE.
- A handshake (req_valid&&req_ready) SHALL latch rs1, rs2, rd, rd_we and rd_wdata.
- The FSM SHALL then go to RD1.
REQ-015 RD1 SHALL drive rf_register=rs1, capture rf_readData into rs1_data at the clock edge, and go to RD2.
REQ-016 RD2 SHALL drive rf_register=rs2, capture rf_readData into rs2_data, and go to WR if latched rd_we=1 and rd!=0, otherwise to RESP.
REQ-017 WR SHALL drive rf_register=rd, rf_writeEnable=1 and rf_writeData=latched rd_wdata for exactly one cycle, then go to RESP.
REQ-018 Outside WR, rf_writeEnable SHALL be 0, rf_writeData SHALL be 0, and rf_register SHALL be 0 in IDLE and RESP.
REQ-019 RESP SHALL assert rsp_valid and hold rs1_data/rs2_data stable until rsp_ready=1, then return to IDLE.
REQ-020 A write with rd=0 SHALL be dropped: no WR cycle and no rf_writeEnable pulse.
REQ-021 A read of index 0 SHALL return whatever rf_readData presents; no special casing.
REQ-022 Latency SHALL be:
- Request accepted at edge N.
- rsp_valid first high after edge N+3 without a write, or N+4 with a write.
REQ-023 A new request SHALL be accepted no earlier than the cycle after the response handshake; there is no overlap of transactions.
REQ-024 rsp_ready held at 0 SHALL stall the FSM in RESP indefinitely with all outputs stable.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE from any state, including mid-operation.
REQ-026 Reset SHALL clear rs1_data, rs2_data and all latched request fields to 0.
REQ-027 After reset, rsp_valid=0, rf_writeEnable=0 and req_ready=1, and the aborted transaction SHALL never be responded to.
REQ-028 Reset asserted during WR SHALL leave rf_writeEnable low from the next cycle onward; the write driven in that cycle is not retracted.

Configuration
REQ-029 When macro REGPORT_WRITE_FIRST_EN is defined, the state order SHALL be IDLE->WR(if enabled)->RD1->RD2->RESP, so reads of rd return the new rd_wdata.
REQ-030 When REGPORT_WRITE_FIRST_EN is not defined, the order SHALL be IDLE->RD1->RD2->WR->RESP, so reads return the pre-write value.
REQ-031 Latency and handshake rules SHALL be identical in both configurations.

Verification
REQ-032 Read-only request:
- Stimulus: preload x5=0x11, x6=0x22; request rs1=5, rs2=6, rd_we=0; rsp_ready=1.
- Response: rs1_data=0x11, rs2_data=0x22; rsp_valid 3 cycles after acceptance; no rf_writeEnable pulse.
REQ-033 Read-modify-write ordering:
- Stimulus: x7=0xA; request rs1=7, rs2=7, rd=7, rd_we=1, rd_wdata=0xB.
- Response without macro: rs1_data=rs2_data=0xA, then x7=0xB.
- Response with macro: rs1_data=rs2_data=0xB.
REQ-034 x0 write suppression:
- Stimulus: request rd=0, rd_we=1, rd_wdata=0xFFFF_FFFF.
- Response: no rf_writeEnable pulse; rsp_valid 3 cycles after acceptance.
REQ-035 Response backpressure:
- Stimulus: rsp_ready=0 for 5 cycles in RESP, with req_valid=1 throughout.
- Response: rsp_valid and data stable; req_ready=0; next request accepted only after the rsp handshake.
REQ-036 Reset during WR:
- Stimulus: rst=1 in the WR cycle.
- Response: next cycle IDLE, rsp_valid=0, rs1_data=rs2_data=0, rf_writeEnable=0, req_ready=1.
